// File: rtl/edge_event_arbiter_if.sv
// edge_event_arbiter_if
// Purpose: valid/ready event stream leaving the edge-detect cluster.
//   The master (edge_event_arbiter) presents one event at a time; the
//   slave (event logger / interrupt block) accepts it with evt_ready.
// Signals:
//   evt_valid   - an event is presented
//   evt_ready   - consumer accepts the presented event
//   evt_chan    - channel index of the event (CW bits)
//   evt_is_rise - 1 = rising edge, 0 = falling edge
//   evt_stamp   - timestamp captured when the edge pulse was sampled
interface edge_event_arbiter_if #(
  parameter int N_CH = 4,
  parameter int TSW  = 16
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic           evt_valid;
  logic           evt_ready;
  logic [CW-1:0]  evt_chan;
  logic           evt_is_rise;
  logic [TSW-1:0] evt_stamp;

  modport master (
    output evt_valid,
    output evt_chan,
    output evt_is_rise,
    output evt_stamp,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_chan,
    input  evt_is_rise,
    input  evt_stamp,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Purpose: collects one-cycle rise/fall pulses from N_CH edge highlighters,
//   buffers one pending timestamped event per channel per edge type, and
//   serialises them round-robin onto a single valid/ready event stream.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   rise_pulse - per-channel rising-edge pulses (bit i = channel i)
//   fall_pulse - per-channel falling-edge pulses (bit i = channel i)
//   ovf_clr    - one-cycle pulse clearing all overflow flags
//   ovf        - sticky per-channel overflow flags
//   evt        - output event stream (master side)
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int TSW  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            rise_pulse,
  input  logic [N_CH-1:0]            fall_pulse,
  input  logic                       ovf_clr,
  output logic [N_CH-1:0]            ovf,
  edge_event_arbiter_if.master       evt
);
  // Slot k = 2*i is channel i rise, 2*i+1 is channel i fall, so the
  // channel index is simply the slot index without its low bit.
  localparam int NS = 2 * N_CH;
  localparam int SW = $clog2(NS);

  logic [TSW-1:0] ts;
  logic [NS-1:0]  pending;
  logic [TSW-1:0] stamp [NS];
  logic [NS-1:0]  pulse;
  logic [SW-1:0]  rr;
  logic [SW-1:0]  win;
  logic           any_pending;
  logic           load_en;
  logic           grant;
  logic [NS-1:0]  gnt_vec;
  logic [N_CH-1:0] ovf_set;

  always_comb begin
    pulse = '0;
    for (int i = 0; i < N_CH; i++) begin
      pulse[2*i]   = rise_pulse[i];
      pulse[2*i+1] = fall_pulse[i];
    end
  end

  // Round-robin search: first pending slot at or after rr, wrapping at NS.
  always_comb begin
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    logic          found;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < NS; off++) begin
      sum = {1'b0, rr} + (SW+1)'(off);
      if (sum >= (SW+1)'(NS)) sum = sum - (SW+1)'(NS);
      idx = sum[SW-1:0];
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign any_pending = |pending;
  assign load_en     = !evt.evt_valid || evt.evt_ready;
  assign grant       = load_en && any_pending;

  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[win] = 1'b1;
  end

  // A pulse into an occupied slot is only an overflow when the slot is not
  // being drained in the same cycle; a granted slot simply takes the new event.
  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < NS; k++) begin
      if (pulse[k] && pending[k] && !gnt_vec[k]) ovf_set[k/2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int k = 0; k < NS; k++) stamp[k] <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (pulse[k] && (!pending[k] || gnt_vec[k])) begin
          pending[k] <= 1'b1;
          stamp[k]   <= ts;
        end else if (gnt_vec[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  // Output register reloads only when empty or being accepted, which keeps
  // the presented event stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt.evt_valid   <= 1'b0;
      evt.evt_chan    <= '0;
      evt.evt_is_rise <= 1'b0;
      evt.evt_stamp   <= '0;
      rr              <= '0;
    end else if (load_en) begin
      if (any_pending) begin
        evt.evt_valid   <= 1'b1;
        evt.evt_chan    <= win[SW-1:1];
        evt.evt_is_rise <= ~win[0];
        evt.evt_stamp   <= stamp[win];
        rr              <= (win == SW'(NS - 1)) ? '0 : win + 1'b1;
      end else begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

  // Clear first, then OR in new overflows so a simultaneous set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= '0;
    else        ovf <= (ovf_clr ? '0 : ovf) | ovf_set;
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter
// Purpose: self-checking bench for edge_event_arbiter (N_CH=4, TSW=4).
//   Expected events are queued when pulses are driven and compared against
//   events observed on accepted handshakes.
module tb_edge_event_arbiter;
  localparam int N_CH = 4;
  localparam int TSW  = 4;

  typedef struct packed {
    logic [1:0]     chan;
    logic           rise;
    logic [TSW-1:0] stamp;
  } ev_t;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic            ovf_clr;
  logic [N_CH-1:0] ovf;
  logic [TSW-1:0]  tb_ts;

  int total = 0;
  int bad   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  edge_event_arbiter_if #(.N_CH(N_CH), .TSW(TSW)) ev_if ();

  edge_event_arbiter #(.N_CH(N_CH), .TSW(TSW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .ovf_clr    (ovf_clr),
    .ovf        (ovf),
    .evt        (ev_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the free-running timestamp counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;
  end

  function automatic ev_t mk(input logic [1:0] c, input logic r, input logic [TSW-1:0] s);
    ev_t e;
    e.chan  = c;
    e.rise  = r;
    e.stamp = s;
    return e;
  endfunction

  // Records the event accepted at the coming edge, then advances one cycle.
  task automatic step();
    if (ev_if.evt_valid && ev_if.evt_ready)
      obs_q.push_back(mk(ev_if.evt_chan, ev_if.evt_is_rise, ev_if.evt_stamp));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ts(input logic [TSW-1:0] v);
    int n;
    n = 0;
    while (tb_ts != v && n < 40) begin
      step();
      n++;
    end
    if (tb_ts != v) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_ts timeout got=%0d want=%0d", tb_ts, v);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    rise_pulse = '0;
    fall_pulse = '0;
    ovf_clr    = 1'b0;
    ev_if.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (ev_if.evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", ev_if.evt_valid); end
    total++;
    if (ev_if.evt_chan !== 2'd0) begin bad++; $display("[TB] FAIL reset_chan got=%0d want=0", ev_if.evt_chan); end
    total++;
    if (ev_if.evt_is_rise !== 1'b0) begin bad++; $display("[TB] FAIL reset_is_rise got=%b want=0", ev_if.evt_is_rise); end
    total++;
    if (ev_if.evt_stamp !== 4'd0) begin bad++; $display("[TB] FAIL reset_stamp got=%0d want=0", ev_if.evt_stamp); end
    total++;
    if (ovf !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0000", ovf); end
  endtask

  task automatic test_single();
    ev_t e, o;
    do_reset();
    ev_if.evt_ready = 1'b1;
    wait_ts(4'd5);
    rise_pulse = 4'b0001;
    exp_q.push_back(mk(2'd0, 1'b1, 4'd5));
    step();
    rise_pulse = '0;
    total++;
    if (ev_if.evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early got=%b want=0", ev_if.evt_valid); end
    step();
    total++;
    if (ev_if.evt_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_latency got=%b want=1", ev_if.evt_valid); end
    step();
    total++;
    if (ev_if.evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_one_cycle got=%b want=0", ev_if.evt_valid); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL single_evt missing, want chan=%0d rise=%b stamp=%0d", e.chan, e.rise, e.stamp);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL single_evt got chan=%0d rise=%b stamp=%0d want chan=%0d rise=%b stamp=%0d", o.chan, o.rise, o.stamp, e.chan, e.rise, e.stamp); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL single_extra got=%0d extra events want=0", obs_q.size()); end
  endtask

  task automatic test_round_robin();
    ev_t e, o;
    logic [TSW-1:0] s;
    do_reset();
    ev_if.evt_ready = 1'b1;
    repeat (2) step();
    s = tb_ts;
    rise_pulse = 4'b0101;
    fall_pulse = 4'b0001;
    exp_q.push_back(mk(2'd0, 1'b1, s));
    exp_q.push_back(mk(2'd0, 1'b0, s));
    exp_q.push_back(mk(2'd2, 1'b1, s));
    step();
    rise_pulse = '0;
    fall_pulse = '0;
    repeat (4) step();
    total++;
    if (obs_q.size() != 3) begin bad++; $display("[TB] FAIL rr_back_to_back got=%0d events want=3", obs_q.size()); end
    // rr now points at slot 5, so ch3 rise (slot 6) beats ch0 rise (slot 0).
    s = tb_ts;
    rise_pulse = 4'b1001;
    exp_q.push_back(mk(2'd3, 1'b1, s));
    exp_q.push_back(mk(2'd0, 1'b1, s));
    step();
    rise_pulse = '0;
    repeat (4) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL rr_evt missing, want chan=%0d rise=%b stamp=%0d", e.chan, e.rise, e.stamp);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL rr_evt got chan=%0d rise=%b stamp=%0d want chan=%0d rise=%b stamp=%0d", o.chan, o.rise, o.stamp, e.chan, e.rise, e.stamp); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL rr_extra got=%0d extra events want=0", obs_q.size()); end
  endtask

  task automatic test_backpressure();
    ev_t e, o, held;
    logic [TSW-1:0] s;
    do_reset();
    wait_ts(4'd3);
    s = tb_ts;
    fall_pulse = 4'b0010;
    exp_q.push_back(mk(2'd1, 1'b0, s));
    step();
    fall_pulse = '0;
    step();
    held = mk(2'd1, 1'b0, s);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (!ev_if.evt_valid || mk(ev_if.evt_chan, ev_if.evt_is_rise, ev_if.evt_stamp) !== held) begin
        bad++;
        $display("[TB] FAIL bp_stable cycle=%0d got valid=%b chan=%0d rise=%b stamp=%0d want valid=1 chan=1 rise=0 stamp=%0d",
                 c, ev_if.evt_valid, ev_if.evt_chan, ev_if.evt_is_rise, ev_if.evt_stamp, s);
      end
      step();
    end
    ev_if.evt_ready = 1'b1;
    step();
    total++;
    if (ev_if.evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drop got=%b want=0", ev_if.evt_valid); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL bp_evt missing, want chan=%0d rise=%b stamp=%0d", e.chan, e.rise, e.stamp);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL bp_evt got chan=%0d rise=%b stamp=%0d want chan=%0d rise=%b stamp=%0d", o.chan, o.rise, o.stamp, e.chan, e.rise, e.stamp); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL bp_extra got=%0d extra events want=0", obs_q.size()); end
  endtask

  task automatic test_overflow();
    ev_t e, o;
    do_reset();
    wait_ts(4'd7);
    fall_pulse = 4'b0001;
    exp_q.push_back(mk(2'd0, 1'b0, 4'd7));
    step();
    fall_pulse = '0;
    wait_ts(4'd10);
    rise_pulse = 4'b1000;
    exp_q.push_back(mk(2'd3, 1'b1, 4'd10));
    step();
    rise_pulse = '0;
    total++;
    if (ovf !== 4'b0000) begin bad++; $display("[TB] FAIL ovf_early got=%b want=0000", ovf); end
    wait_ts(4'd12);
    rise_pulse = 4'b1000;
    step();
    rise_pulse = '0;
    total++;
    if (ovf !== 4'b1000) begin bad++; $display("[TB] FAIL ovf_set got=%b want=1000", ovf); end
    rise_pulse = 4'b1000;
    ovf_clr = 1'b1;
    step();
    rise_pulse = '0;
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 4'b1000) begin bad++; $display("[TB] FAIL ovf_set_wins got=%b want=1000", ovf); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 4'b0000) begin bad++; $display("[TB] FAIL ovf_clear got=%b want=0000", ovf); end
    ev_if.evt_ready = 1'b1;
    repeat (4) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL ovf_evt missing, want chan=%0d rise=%b stamp=%0d", e.chan, e.rise, e.stamp);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL ovf_evt got chan=%0d rise=%b stamp=%0d want chan=%0d rise=%b stamp=%0d", o.chan, o.rise, o.stamp, e.chan, e.rise, e.stamp); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL ovf_extra got=%0d extra events want=0", obs_q.size()); end
  endtask

  task automatic test_collision();
    ev_t e, o;
    do_reset();
    ev_if.evt_ready = 1'b1;
    wait_ts(4'd2);
    rise_pulse = 4'b0100;
    exp_q.push_back(mk(2'd2, 1'b1, tb_ts));
    step();
    // Slot 4 is granted at this coming edge while a new pulse arrives.
    exp_q.push_back(mk(2'd2, 1'b1, tb_ts));
    step();
    rise_pulse = '0;
    total++;
    if (ovf !== 4'b0000) begin bad++; $display("[TB] FAIL coll_no_ovf got=%b want=0000", ovf); end
    repeat (4) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL coll_evt missing, want chan=%0d rise=%b stamp=%0d", e.chan, e.rise, e.stamp);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL coll_evt got chan=%0d rise=%b stamp=%0d want chan=%0d rise=%b stamp=%0d", o.chan, o.rise, o.stamp, e.chan, e.rise, e.stamp); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL coll_extra got=%0d extra events want=0", obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    logic seen;
    do_reset();
    wait_ts(4'd3);
    rise_pulse = 4'b1110;
    fall_pulse = 4'b0010;
    step();
    rise_pulse = '0;
    fall_pulse = '0;
    step();
    ev_if.evt_ready = 1'b1;
    total++;
    if (ev_if.evt_valid !== 1'b1 || ev_if.evt_chan !== 2'd1 || ev_if.evt_stamp !== 4'd3) begin
      bad++; $display("[TB] FAIL mid_presented got valid=%b chan=%0d stamp=%0d want valid=1 chan=1 stamp=3", ev_if.evt_valid, ev_if.evt_chan, ev_if.evt_stamp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ev_if.evt_valid !== 1'b0 || ev_if.evt_chan !== 2'd0 || ev_if.evt_is_rise !== 1'b0 ||
        ev_if.evt_stamp !== 4'd0 || ovf !== 4'b0000) begin
      bad++; $display("[TB] FAIL mid_async_clear got valid=%b chan=%0d rise=%b stamp=%0d ovf=%b want all zero",
                      ev_if.evt_valid, ev_if.evt_chan, ev_if.evt_is_rise, ev_if.evt_stamp, ovf);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      seen = seen | ev_if.evt_valid;
    end
    total++;
    if (seen !== 1'b0 || obs_q.size() != 0) begin
      bad++; $display("[TB] FAIL mid_stale got valid_seen=%b events=%0d want 0 and 0", seen, obs_q.size());
    end
    fall_pulse = 4'b0001;
    exp_q.push_back(mk(2'd0, 1'b0, tb_ts));
    step();
    fall_pulse = '0;
    repeat (3) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL mid_evt missing, want chan=%0d rise=%b stamp=%0d", e.chan, e.rise, e.stamp);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL mid_evt got chan=%0d rise=%b stamp=%0d want chan=%0d rise=%b stamp=%0d", o.chan, o.rise, o.stamp, e.chan, e.rise, e.stamp); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL mid_extra got=%0d extra events want=0", obs_q.size()); end
  endtask

  task automatic test_wrap();
    ev_t e, o;
    do_reset();
    ev_if.evt_ready = 1'b1;
    repeat (20) step();
    wait_ts(4'd15);
    step();
    fall_pulse = 4'b1000;
    exp_q.push_back(mk(2'd3, 1'b0, 4'd0));
    step();
    fall_pulse = '0;
    repeat (3) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("[TB] FAIL wrap_evt missing, want chan=%0d rise=%b stamp=%0d", e.chan, e.rise, e.stamp);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("[TB] FAIL wrap_evt got chan=%0d rise=%b stamp=%0d want chan=%0d rise=%b stamp=%0d", o.chan, o.rise, o.stamp, e.chan, e.rise, e.stamp); end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL wrap_extra got=%0d extra events want=0", obs_q.size()); end
  endtask

  initial begin
    rst_n      = 1'b0;
    rise_pulse = '0;
    fall_pulse = '0;
    ovf_clr    = 1'b0;
    ev_if.evt_ready = 1'b0;
    $display("[TB] starting edge_event_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

- Collects rising/falling edge pulses from `N_CH` edge highlighter instances.
- Buffers one pending event per channel per edge type, tagged with a capture timestamp.
- Serialises those events onto a single valid/ready output stream using round-robin arbitration.
- Sits between the per-signal edge highlighters and the event logger/interrupt block; it is the only path by which edge events leave the edge-detect cluster.

## Interface

Parameters:
- `N_CH`, default 4 — number of edge highlighter channels; legal range 2..16.
- `TSW`, default 16 — timestamp counter width.
- `CW`, derived as max(1, clog2(N_CH)) — channel index width; not user-settable.

Ports:
- `clk` — in, 1 — single clock for the whole block.
- `rst_n` — in, 1 — reset, asynchronous, active-low.
- `rise_pulse` — in, N_CH — one-cycle rising-edge pulses; bit i belongs to channel i.
- `fall_pulse` — in, N_CH — one-cycle falling-edge pulses; bit i belongs to channel i.
- `evt_valid` — out, 1 — an output event is presented.
- `evt_ready` — in, 1 — the consumer accepts the event.
- `evt_chan` — out, CW — channel index of the presented event.
- `evt_is_rise` — out, 1 — 1 = rising edge, 0 = falling edge.
- `evt_stamp` — out, TSW — timestamp captured when the edge pulse was sampled.
- `ovf` — out, N_CH — sticky per-channel overflow flags.
- `ovf_clr` — in, 1 — one-cycle pulse that clears all `ovf` bits.

## Operation

- **Timestamp counter `ts`:**
  - Free-running; increments by 1 every cycle.
  - Wraps from 2^TSW−1 to 0.
- **Slots:** 2·N_CH slots, where slot k = 2·i for channel i rise and 2·i+1 for channel i fall.
  - Each slot holds a pending bit and a TSW-bit stamp.
- **Capture:** when a pulse bit is 1 at a rising `clk` edge:
  - If the slot is not pending: set pending and store the stamp = `ts` value at that edge (the pre-increment value).
  - If the slot is pending and is not being granted in the same cycle: the new event is dropped, the stored stamp is kept, and `ovf[i]` is set.
  - If the slot is being granted in the same cycle: pending stays 1 and the stamp is updated to the new value. This is not an overflow.
- **Arbitration:** round-robin over the 2·N_CH pending bits.
  - The search starts at pointer `rr`.
  - After granting slot k, `rr` becomes (k+1) mod 2·N_CH.
  - `rr` is unchanged when nothing is granted.
- **Output register load:** happens when the register is empty (`evt_valid`=0) or on a handshake (`evt_valid` & `evt_ready`).
  - If any slot is pending: load the winner's channel, type and stamp, set `evt_valid`=1, and clear the winner's pending bit in the same cycle.
  - Otherwise: set `evt_valid`=0.
- **Stability under backpressure:** while `evt_valid`=1 and `evt_ready`=0, all `evt_*` outputs hold stable.
- **Overflow flags:** `ovf` bits are sticky.
  - `ovf_clr` clears all bits.
  - A set in the same cycle as `ovf_clr` wins, so that bit stays 1.
- **Reset (asserted at any time, including mid-handshake):** immediately clears:
  - `ts`, `rr`, all pending bits and stamps;
  - `evt_valid`, `evt_chan`, `evt_is_rise`, `evt_stamp`;
  - `ovf`.
  - Events in flight are discarded.
  - First capture possible at the first rising edge after `rst_n` deasserts.

## Timing

- **Reset values:** `evt_valid`=0, `evt_chan`=0, `evt_is_rise`=0, `evt_stamp`=0, `ovf`=0.
- **Latency:** pulse sampled at edge E → pending after E → `evt_valid`=1 after edge E+1, provided the output register was empty and the slot wins arbitration.
- **Throughput:** one event per cycle while `evt_ready`=1 and slots are pending. Back-to-back events are presented with no bubble.
- **Buffering:** capacity is 2·N_CH pending events plus 1 in the output register.
- **Simultaneous rise and fall on one channel:** both slots are set and are granted in round-robin order.
- **Input and clock relation:** `evt_ready` and `ovf_clr` are sampled only on rising `clk` edges. No combinational path exists from inputs to outputs.

## Test plan

- **Single event:**
  - Stimulus: reset; pulse `rise_pulse[0]` at the edge where `ts`=5; hold `evt_ready`=1.
  - Response: `evt_valid`=1 for exactly one cycle, one cycle after capture, with `evt_chan`=0, `evt_is_rise`=1, `evt_stamp`=5.
- **Round-robin:**
  - Stimulus: `rise_pulse`=4'b0101 and `fall_pulse`=4'b0001 in the same cycle; `evt_ready`=1.
  - Response: events emerge in the order (0,rise), (0,fall), (2,rise) on consecutive cycles, all with the same stamp. After this, `rr`=5.
- **Backpressure:**
  - Stimulus: capture an event on ch1 fall; hold `evt_ready`=0 for 4 cycles, then 1.
  - Response: outputs stay stable for all 4 cycles; `evt_valid` drops the cycle after acceptance.
- **Overflow:**
  - Stimulus: with `evt_ready`=0, pulse `rise_pulse[3]` at `ts`=10 and again at `ts`=12 (the output register is already full).
  - Response: `ovf[3]`=1 and the later-emitted stamp is 10.
  - Stimulus: `ovf_clr` together with a new overflow on ch3.
  - Response: `ovf[3]` stays 1.
  - Stimulus: a lone `ovf_clr`.
  - Response: `ovf`=0.
- **Grant/capture collision:**
  - Stimulus: a new `rise_pulse[2]` in the same cycle its slot is granted.
  - Response: no overflow, and a second ch2 rise event follows carrying the new stamp.
- **Reset and wrap:**
  - Stimulus: assert `rst_n`=0 mid-handshake with 3 pending events.
  - Response: all outputs go to 0 immediately and no stale events appear after release.
  - Stimulus: with TSW=4, let `ts` run past 15.
  - Response: a capture at wrap records stamp 0.
